// File: rtl/lifo_pkg.sv
// Shared definitions for the parametrised LIFO stack.
package lifo_pkg;

    // Default geometry, matching the legacy 4-bit / 16-entry stack.
    localparam int LIFO_DATA_W = 4;
    localparam int LIFO_DEPTH  = 16;

    // Encoding follows {push, pop}, so the request pair casts straight to an op.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } op_t;

endpackage

// File: rtl/lifo_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module lifo_ram #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; the read port below sees the new value from the next cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_p.sv
// Parametrised single-clock LIFO stack with registered pop data, top-replace
// (swap), occupancy flags and overflow/underflow reporting.
module lifo_stack_p
    import lifo_pkg::*;
#(
    parameter  int DATA_W   = LIFO_DATA_W,
    parameter  int DEPTH    = LIFO_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic              src_sel,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    output logic              err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    op_t               op;
    logic [DATA_W-1:0] din;
    logic [CNT_W-1:0]  sp;
    logic [AW-1:0]     top_addr;
    logic [AW-1:0]     ram_waddr;
    logic              ram_we;
    logic [DATA_W-1:0] top_data;

    assign din = src_sel ? data_in : pc_in;
    assign op  = op_t'({push, pop});

    // Flags derive from the registered stack pointer only.
    assign count       = sp;
    assign full        = (sp == CNT_W'(DEPTH));
    assign empty       = (sp == '0);
    assign almost_full = (sp >= CNT_W'(AF_LEVEL));

    // Top-of-stack address; parked at 0 when empty so it never leaves the array.
    assign top_addr = empty ? '0 : AW'(sp - CNT_W'(1));

    // Write port control: push writes above the top, swap overwrites the top.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = AW'(sp);
        case (op)
            OP_PUSH: ram_we = !full;
            OP_SWAP: begin
                ram_we    = !empty;
                ram_waddr = top_addr;
            end
            default: ram_we = 1'b0;
        endcase
        if (clear) begin
            ram_we = 1'b0;
        end
    end

    lifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (din),
        .raddr (top_addr),
        .rdata (top_data)
    );

    // Stack pointer, output register, error pulses and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err       <= 1'b0;
        end else if (clear) begin
            sp        <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            // Sticky error picks up last cycle's pulses, one edge later.
            err       <= err | overflow | underflow;
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        sp <= sp + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        underflow <= 1'b1;
                    end else begin
                        data_out  <= top_data;
                        out_valid <= 1'b1;
                        sp        <= sp - CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    // Empty swap passes the write data straight through.
                    data_out  <= empty ? din : top_data;
                    out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_stack_p.sv
// Self-checking bench for lifo_stack_p (DATA_W=4, DEPTH=4, AF_LEVEL=3).
module tb_lifo_stack_p;

    localparam int DW = 4;
    localparam int DP = 4;
    localparam int AF = 3;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          src_sel = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] pc_in = '0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, overflow, underflow, err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout = '0;
    logic          m_valid = 1'b0;
    logic          m_ov = 1'b0;
    logic          m_uf = 1'b0;
    logic          m_err = 1'b0;

    lifo_stack_p #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .push        (push),
        .pop         (pop),
        .src_sel     (src_sel),
        .data_in     (data_in),
        .pc_in       (pc_in),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ov    = 1'b0;
        m_uf    = 1'b0;
        m_err   = 1'b0;
    endtask

    // Apply one operation across one rising edge and advance the model.
    task automatic cycle(input logic p, input logic q, input logic clr, input logic sel,
                         input logic [DW-1:0] d, input logic [DW-1:0] pcv);
        logic [DW-1:0] w;
        logic          ov, uf, vld;
        @(negedge clk);
        push = p; pop = q; clear = clr; src_sel = sel; data_in = d; pc_in = pcv;
        @(posedge clk);
        w = sel ? d : pcv;
        ov = 1'b0; uf = 1'b0; vld = 1'b0;
        if (clr) begin
            m_q.delete();
            m_err = 1'b0;
        end else begin
            m_err = m_err | m_ov | m_uf;
            if (p && !q) begin
                if (m_q.size() < DP) m_q.push_back(w);
                else ov = 1'b1;
            end else if (!p && q) begin
                if (m_q.size() > 0) begin
                    m_dout = m_q.pop_back();
                    vld = 1'b1;
                end else uf = 1'b1;
            end else if (p && q) begin
                vld = 1'b1;
                if (m_q.size() > 0) begin
                    m_dout = m_q[m_q.size()-1];
                    m_q[m_q.size()-1] = w;
                end else m_dout = w;
            end
        end
        m_ov = ov; m_uf = uf; m_valid = vld;
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        n_tests++;
        if ({count, empty, full, almost_full} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b af=%b, want 0/1/0/0",
                     count, empty, full, almost_full);
        end
        n_tests++;
        if ({data_out, out_valid, overflow, underflow, err} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: dout=%h vld=%b ov=%b uf=%b err=%b, want all 0",
                     data_out, out_valid, overflow, underflow, err);
        end
    endtask

    task automatic test_push_pop();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, DW'(i), 4'hF);
            n_tests++;
            if (count !== CW'(i) || almost_full !== (i >= 3) || full !== (i == 4)) begin
                n_fail++;
                $display("FAIL push_flags[%0d]: count=%0d af=%b full=%b, want %0d/%b/%b",
                         i, count, almost_full, full, i, i >= 3, i == 4);
            end
        end
        for (int i = 4; i >= 1; i--) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            n_tests++;
            if (data_out !== DW'(i) || out_valid !== 1'b1 || count !== CW'(i - 1)) begin
                n_fail++;
                $display("FAIL pop_order[%0d]: dout=%h vld=%b count=%0d, want %h/1/%0d",
                         i, data_out, out_valid, count, i, i - 1);
            end
        end
        idle();
        n_tests++;
        if (empty !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_drain: empty=%b vld=%b, want 1/0", empty, out_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, DW'(i), '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'hA, '0);
        n_tests++;
        if (overflow !== 1'b1 || count !== CW'(4) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pulse: ov=%b count=%0d err=%b, want 1/4/0",
                     overflow, count, err);
        end
        idle();
        n_tests++;
        if (overflow !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_err: ov=%b err=%b, want 0/1", overflow, err);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (data_out !== 4'h4 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_top: dout=%h vld=%b, want 4/1", data_out, out_valid);
        end
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_underflow_clear();
        logic [DW-1:0] prev;
        prev = data_out;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (underflow !== 1'b1 || out_valid !== 1'b0 || data_out !== prev) begin
            n_fail++;
            $display("FAIL underflow_pulse: uf=%b vld=%b dout=%h, want 1/0/%h",
                     underflow, out_valid, data_out, prev);
        end
        idle();
        n_tests++;
        if (underflow !== 1'b0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_err: uf=%b err=%b, want 0/1", underflow, err);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'h7, '0);
        n_tests++;
        if (err !== 1'b0 || count !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: err=%b count=%0d vld=%b, want 0/0/0", err, count, out_valid);
        end
    endtask

    task automatic test_swap();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h6, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hC);
        n_tests++;
        if (data_out !== 4'h6 || out_valid !== 1'b1 || count !== CW'(2)) begin
            n_fail++;
            $display("FAIL swap_top: dout=%h vld=%b count=%0d, want 6/1/2",
                     data_out, out_valid, count);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        n_tests++;
        if (data_out !== 4'hC) begin
            n_fail++;
            $display("FAIL swap_written: dout=%h, want c", data_out);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'h9, 4'h3);
        n_tests++;
        if (data_out !== 4'h9 || out_valid !== 1'b1 || count !== '0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_empty: dout=%h vld=%b count=%0d uf=%b, want 9/1/0/0",
                     data_out, out_valid, count, underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h2, '0);
        for (int i = 0; i < 6; i++) begin
            v = DW'($urandom);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, v);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
            n_tests++;
            if (data_out !== v || count !== CW'(1) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL push_then_pop[%0d]: dout=%h count=%0d vld=%b, want %h/1/1",
                         i, data_out, count, out_valid, v);
            end
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom),
                  DW'($urandom), DW'($urandom));
            n_tests++;
            if (count !== CW'(m_q.size()) || full !== (m_q.size() == DP) ||
                empty !== (m_q.size() == 0) || almost_full !== (m_q.size() >= AF) ||
                out_valid !== m_valid || overflow !== m_ov || underflow !== m_uf ||
                err !== m_err || data_out !== m_dout) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d]: cnt=%0d dout=%h vld=%b ov=%b uf=%b err=%b, want %0d/%h/%b/%b/%b/%b",
                             i, count, data_out, out_valid, overflow, underflow, err,
                             m_q.size(), m_dout, m_valid, m_ov, m_uf, m_err);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h1, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'h2, '0);
        @(negedge clk);
        push = 1'b1; pop = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (count !== '0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d empty=%b, want 0/1", count, empty);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle();
        n_tests++;
        if (count !== '0 || data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_release: count=%0d dout=%h, want 0/0", count, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow_clear();
        test_swap();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
